// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline-side signal bundle for the CP0 register file / exception sequencer.
// The slave modport is the CP0 block; the master modport is the pipeline driving it.
interface cp0_exc_ctrl_if;
  logic        stall;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [5:0]  int_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic        flush_o;
  logic [31:0] newpc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;

  modport slave (
    input  stall, excepttype_i, pc_i, in_delayslot_i, bad_addr_i, int_i,
    input  we_i, waddr_i, wdata_i, raddr_i,
    output rdata_o, flush_o, newpc_o, status_o, cause_o, epc_o, timer_int_o
  );

  modport master (
    output stall, excepttype_i, pc_i, in_delayslot_i, bad_addr_i, int_i,
    output we_i, waddr_i, wdata_i, raddr_i,
    input  rdata_o, flush_o, newpc_o, status_o, cause_o, epc_o, timer_int_o
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file (BadVAddr/Count/Compare/Status/Cause/EPC) with a two-state
// exception-commit sequencer and the Count/Compare timer.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned COUNT_DIV  = 1
) (
  input  logic          clk,
  input  logic          rst,
  cp0_exc_ctrl_if.slave bus
);

  localparam int unsigned      DIV_W    = (COUNT_DIV > 0) ? $clog2(COUNT_DIV + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam logic [31:0] CODE_ADEL = 32'h0000_0004;
  localparam logic [31:0] CODE_ADES = 32'h0000_0005;
  localparam logic [31:0] CODE_ERET = 32'h0000_000E;

  typedef enum logic {IDLE, FLUSH} state_t;

  function automatic logic [4:0] exc_code(input logic [31:0] code);
    logic [4:0] ec;
    case (code)
      32'h1:   ec = 5'h00;
      32'h4:   ec = 5'h04;
      32'h5:   ec = 5'h05;
      32'h8:   ec = 5'h08;
      32'h9:   ec = 5'h09;
      32'hA:   ec = 5'h0A;
      32'hC:   ec = 5'h0C;
      default: ec = 5'h0A;
    endcase
    return ec;
  endfunction

  function automatic logic [31:0] wmask(input logic [4:0] addr);
    logic [31:0] m;
    case (addr)
      REG_COUNT, REG_COMPARE, REG_EPC: m = '1;
      REG_STATUS:                      m = STATUS_WMASK;
      REG_CAUSE:                       m = CAUSE_WMASK;
      default:                         m = '0;
    endcase
    return m;
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      badvaddr_q, badvaddr_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic [31:0]      status_q, status_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      epc_q, epc_d;
  logic             timer_q, timer_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic        commit;
  logic        eret;
  logic        mtc0;
  logic [31:0] rd_reg;

  // Commit only from IDLE; FLUSH is the one-cycle bubble behind a redirect.
  always_comb begin
    commit  = (state_q == IDLE) && (bus.excepttype_i != 32'd0) && !bus.stall;
    eret    = (bus.excepttype_i == CODE_ERET);
    mtc0    = bus.we_i && !commit;
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.flush_o = commit;
  assign bus.newpc_o = !commit ? 32'd0 : (eret ? epc_q : EXC_VECTOR);

  // Count/Compare timer; an MTC0 to Count restarts the prescaler too.
  always_comb begin
    count_d   = count_q;
    div_d     = div_q;
    compare_d = compare_q;
    timer_d   = timer_q;
    if (mtc0 && bus.waddr_i == REG_COUNT) begin
      count_d = bus.wdata_i;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      count_d = count_q + 32'd1;
      div_d   = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
    if (count_q == compare_q && compare_q != 32'd0) timer_d = 1'b1;
    if (mtc0 && bus.waddr_i == REG_COMPARE) begin
      compare_d = bus.wdata_i;
      timer_d   = 1'b0;
    end
  end

  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    cause_d    = {cause_q[31:16], bus.int_i[5] | timer_q, bus.int_i[4:0], cause_q[9:0]};
    if (commit) begin
      if (eret) begin
        status_d[1] = 1'b0;
      end else begin
        status_d[1] = 1'b1;
        // A nested exception keeps the original return address and BD.
        if (!status_q[1]) begin
          epc_d       = bus.in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
          cause_d[31] = bus.in_delayslot_i;
        end
        cause_d[6:2] = exc_code(bus.excepttype_i);
        if (bus.excepttype_i == CODE_ADEL || bus.excepttype_i == CODE_ADES)
          badvaddr_d = bus.bad_addr_i;
      end
    end else if (mtc0) begin
      case (bus.waddr_i)
        REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK);
        REG_CAUSE:  cause_d  = (cause_d & ~CAUSE_WMASK) | (bus.wdata_i & CAUSE_WMASK);
        REG_EPC:    epc_d    = bus.wdata_i;
        default:    ;
      endcase
    end
  end

  always_comb begin
    rd_reg = 32'd0;
    case (bus.raddr_i)
      REG_BADVADDR: rd_reg = badvaddr_q;
      REG_COUNT:    rd_reg = count_q;
      REG_COMPARE:  rd_reg = compare_q;
      REG_STATUS:   rd_reg = status_q;
      REG_CAUSE:    rd_reg = cause_q;
      REG_EPC:      rd_reg = epc_q;
      default:      rd_reg = 32'd0;
    endcase
  end

  assign bus.rdata_o = (mtc0 && bus.waddr_i == bus.raddr_i)
                     ? (bus.wdata_i & wmask(bus.raddr_i)) : rd_reg;

  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_q;
  assign bus.epc_o       = epc_q;
  assign bus.timer_int_o = timer_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RESET;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      timer_q    <= 1'b0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed vector table, hand-written timer/reset
// sequences, then random traffic against a register-array reference model.
module tb_cp0_exc_ctrl;
  localparam logic [31:0] VEC       = 32'hBFC00380;
  localparam int          COUNT_DIV = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl #(.EXC_VECTOR(VEC), .COUNT_DIV(COUNT_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [31:0] ex;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic        fl;
    logic [31:0] np;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t v(input logic st, input logic [31:0] ex, input logic [31:0] pc,
                             input logic ds, input logic [31:0] bad, input logic we,
                             input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra,
                             input logic fl, input logic [31:0] np, input logic [31:0] rd);
    vec_t r;
    r.st = st; r.ex = ex; r.pc = pc; r.ds = ds; r.bad = bad; r.we = we;
    r.wa = wa; r.wd = wd; r.ra = ra; r.fl = fl; r.np = np; r.rd = rd;
    return r;
  endfunction

  task automatic drive_idle();
    bus.stall = 0; bus.excepttype_i = 0; bus.pc_i = 0; bus.in_delayslot_i = 0;
    bus.bad_addr_i = 0; bus.int_i = 0; bus.we_i = 0; bus.waddr_i = 0;
    bus.wdata_i = 0; bus.raddr_i = 0;
  endtask

  // Reference model: register file as an array indexed by CP0 number.
  logic [31:0] mreg [32];
  logic        m_timer;
  logic        m_bubble;
  int          m_ticks;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mreg[12] = 32'h00400000;
    m_timer = 0; m_bubble = 0; m_ticks = 0;
  endtask

  function automatic logic [31:0] m_mask(input int a);
    if (a == 9 || a == 11 || a == 14) return 32'hFFFFFFFF;
    if (a == 12) return 32'h0000FF03;
    if (a == 13) return 32'h00000300;
    return 32'd0;
  endfunction

  function automatic logic [4:0] m_code(input logic [31:0] c);
    if (c == 1) return 5'd0;
    if (c == 4 || c == 5 || c == 8 || c == 9 || c == 10 || c == 12) return c[4:0];
    return 5'd10;
  endfunction

  function automatic logic m_commit();
    return !m_bubble && bus.excepttype_i != 0 && !bus.stall;
  endfunction

  task automatic model_check(input int cyc);
    logic        c;
    logic [31:0] np, rd;
    string       s;
    c  = m_commit();
    np = !c ? 32'd0 : (bus.excepttype_i == 32'hE ? mreg[14] : VEC);
    rd = (bus.we_i && !c && bus.waddr_i == bus.raddr_i)
         ? bus.wdata_i & m_mask(int'(bus.raddr_i)) : mreg[bus.raddr_i];
    s = $sformatf("rnd%0d", cyc);
    chk({s, ".flush"}, 32'(bus.flush_o), 32'(c));
    chk({s, ".newpc"}, bus.newpc_o, np);
    chk({s, ".rdata"}, bus.rdata_o, rd);
    chk({s, ".status"}, bus.status_o, mreg[12]);
    chk({s, ".cause"}, bus.cause_o, mreg[13]);
    chk({s, ".epc"}, bus.epc_o, mreg[14]);
    chk({s, ".timer"}, 32'(bus.timer_int_o), 32'(m_timer));
  endtask

  task automatic model_step();
    logic [31:0] nr [32];
    logic        nt, c, cnt_wr;
    int          w;
    nr = mreg;
    nt = m_timer;
    c  = m_commit();
    cnt_wr = 0;
    w  = int'(bus.waddr_i);
    if (mreg[9] == mreg[11] && mreg[11] != 0) nt = 1;
    if (m_ticks % (COUNT_DIV + 1) == COUNT_DIV) nr[9] = mreg[9] + 1;
    nr[13][15:10] = {bus.int_i[5] | m_timer, bus.int_i[4:0]};
    if (c) begin
      if (bus.excepttype_i == 32'hE) nr[12][1] = 0;
      else begin
        if (!mreg[12][1]) begin
          nr[14] = bus.pc_i - (bus.in_delayslot_i ? 32'd4 : 32'd0);
          nr[13][31] = bus.in_delayslot_i;
        end
        nr[12][1] = 1;
        nr[13][6:2] = m_code(bus.excepttype_i);
        if (bus.excepttype_i == 4 || bus.excepttype_i == 5) nr[8] = bus.bad_addr_i;
      end
    end else if (bus.we_i) begin
      if (w == 9) begin nr[9] = bus.wdata_i; cnt_wr = 1; end
      else if (w == 11) begin nr[11] = bus.wdata_i; nt = 0; end
      else nr[w] = (nr[w] & ~m_mask(w)) | (bus.wdata_i & m_mask(w));
    end
    m_ticks  = cnt_wr ? 0 : m_ticks + 1;
    mreg     = nr;
    m_timer  = nt;
    m_bubble = c;
  endtask

  vec_t tbl [28];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int five;
    tbl[0]  = v(0, 0,     0,            0, 0, 0, 0,  0,     12, 0, 0,   32'h00400000);
    tbl[1]  = v(0, 0,     0,            0, 0, 0, 0,  0,     13, 0, 0,   0);
    tbl[2]  = v(0, 0,     0,            0, 0, 0, 0,  0,     14, 0, 0,   0);
    tbl[3]  = v(0, 8,     32'h80001000, 0, 0, 0, 0,  0,     14, 1, VEC, 0);
    tbl[4]  = v(0, 0,     0,            0, 0, 0, 0,  0,     14, 0, 0,   32'h80001000);
    tbl[5]  = v(0, 0,     0,            0, 0, 0, 0,  0,     13, 0, 0,   32'h00000020);
    tbl[6]  = v(0, 0,     0,            0, 0, 0, 0,  0,     12, 0, 0,   32'h00400002);
    tbl[7]  = v(0, 32'hE, 0,            0, 0, 0, 0,  0,     14, 1, 32'h80001000, 32'h80001000);
    tbl[8]  = v(0, 0,     0,            0, 0, 0, 0,  0,     12, 0, 0,   32'h00400000);
    tbl[9]  = v(0, 4,     32'h80002004, 1, 3, 0, 0,  0,     8,  1, VEC, 0);
    tbl[10] = v(0, 32'hC, 32'h80002004, 0, 0, 0, 0,  0,     14, 0, 0,   32'h80002000);
    tbl[11] = v(0, 0,     0,            0, 0, 0, 0,  0,     13, 0, 0,   32'h80000010);
    tbl[12] = v(0, 0,     0,            0, 0, 0, 0,  0,     8,  0, 0,   3);
    tbl[13] = v(0, 32'hC, 32'h80003000, 0, 0, 0, 0,  0,     14, 1, VEC, 32'h80002000);
    tbl[14] = v(0, 0,     0,            0, 0, 0, 0,  0,     14, 0, 0,   32'h80002000);
    tbl[15] = v(0, 0,     0,            0, 0, 0, 0,  0,     13, 0, 0,   32'h80000030);
    tbl[16] = v(0, 32'hE, 0,            0, 0, 0, 0,  0,     12, 1, 32'h80002000, 32'h00400002);
    tbl[17] = v(0, 0,     0,            0, 0, 0, 0,  0,     12, 0, 0,   32'h00400000);
    tbl[18] = v(1, 8,     32'h80004000, 0, 0, 0, 0,  0,     12, 0, 0,   32'h00400000);
    tbl[19] = v(1, 8,     32'h80004000, 0, 0, 0, 0,  0,     12, 0, 0,   32'h00400000);
    tbl[20] = v(0, 8,     32'h80004000, 0, 0, 0, 0,  0,     14, 1, VEC, 32'h80002000);
    tbl[21] = v(0, 0,     0,            0, 0, 0, 0,  0,     14, 0, 0,   32'h80004000);
    tbl[22] = v(0, 32'hE, 0,            0, 0, 0, 0,  0,     12, 1, 32'h80004000, 32'h00400002);
    tbl[23] = v(0, 0,     0,            0, 0, 0, 0,  0,     12, 0, 0,   32'h00400000);
    tbl[24] = v(0, 8,     32'h80005000, 0, 0, 1, 14, 32'h1234, 14, 1, VEC, 32'h80004000);
    tbl[25] = v(0, 0,     0,            0, 0, 0, 0,  0,     14, 0, 0,   32'h80005000);
    tbl[26] = v(0, 0,     0,            0, 0, 1, 14, 32'h1234, 14, 0, 0,   32'h00001234);
    tbl[27] = v(0, 0,     0,            0, 0, 0, 0,  0,     14, 0, 0,   32'h00001234);

    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    chk("reset.flush", 32'(bus.flush_o), 0);
    chk("reset.timer", 32'(bus.timer_int_o), 0);
    chk("reset.newpc", bus.newpc_o, 0);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      bus.stall = tbl[i].st; bus.excepttype_i = tbl[i].ex; bus.pc_i = tbl[i].pc;
      bus.in_delayslot_i = tbl[i].ds; bus.bad_addr_i = tbl[i].bad; bus.we_i = tbl[i].we;
      bus.waddr_i = tbl[i].wa; bus.wdata_i = tbl[i].wd; bus.raddr_i = tbl[i].ra;
      #1;
      chk($sformatf("vec%0d.flush", i), 32'(bus.flush_o), 32'(tbl[i].fl));
      chk($sformatf("vec%0d.newpc", i), bus.newpc_o, tbl[i].np);
      chk($sformatf("vec%0d.rdata", i), bus.rdata_o, tbl[i].rd);
    end

    // Timer: Compare=6, then Count=0; fires 13 edges after the Count write.
    @(negedge clk);
    drive_idle();
    bus.we_i = 1; bus.waddr_i = 11; bus.wdata_i = 6;
    @(negedge clk);
    bus.waddr_i = 9; bus.wdata_i = 0;
    @(posedge clk); #1;
    bus.we_i = 0;
    repeat (12) @(posedge clk);
    #1 chk("timer.before", 32'(bus.timer_int_o), 0);
    @(posedge clk); #1;
    chk("timer.fire", 32'(bus.timer_int_o), 1);
    chk("timer.cause15_lag", 32'(bus.cause_o[15]), 0);
    @(posedge clk); #1;
    chk("timer.cause15", 32'(bus.cause_o[15]), 1);
    @(negedge clk);
    bus.we_i = 1; bus.waddr_i = 11; bus.wdata_i = 0;
    @(posedge clk); #1;
    bus.we_i = 0;
    chk("timer.clear", 32'(bus.timer_int_o), 0);
    @(posedge clk); #1;
    chk("timer.cause15_clear", 32'(bus.cause_o[15]), 0);

    // Reset asserted mid FLUSH cycle takes effect without a clock edge.
    @(negedge clk);
    bus.excepttype_i = 8; bus.pc_i = 32'h80006000;
    @(posedge clk); #1;
    bus.excepttype_i = 0; bus.raddr_i = 8;
    #2 rst = 1;
    #1;
    chk("arst.status", bus.status_o, 32'h00400000);
    chk("arst.epc", bus.epc_o, 0);
    chk("arst.cause", bus.cause_o, 0);
    chk("arst.badvaddr", bus.rdata_o, 0);
    chk("arst.flush", 32'(bus.flush_o), 0);
    chk("arst.newpc", bus.newpc_o, 0);
    @(negedge clk);
    rst = 0;
    bus.excepttype_i = 8; bus.pc_i = 32'h80007000;
    #1 chk("arst.idle_commit", 32'(bus.flush_o), 1);

    // Random traffic against the reference model.
    @(negedge clk);
    drive_idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      begin
        logic [31:0] codes [12];
        logic [4:0]  addrs [8];
        codes = '{0, 0, 0, 0, 0, 1, 4, 5, 8, 9, 32'hA, 32'hC};
        addrs = '{8, 9, 11, 12, 13, 14, 3, 0};
        five = $urandom_range(0, 15);
        bus.excepttype_i = (five == 0) ? 32'hE : (five == 1) ? 32'h7 : codes[$urandom_range(0, 11)];
        bus.stall = ($urandom_range(0, 3) == 0);
        bus.pc_i = $urandom & 32'hFFFFFFFC;
        bus.in_delayslot_i = $urandom_range(0, 1);
        bus.bad_addr_i = $urandom;
        bus.int_i = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
        bus.we_i = ($urandom_range(0, 3) == 0);
        bus.waddr_i = addrs[$urandom_range(0, 7)];
        bus.wdata_i = (bus.waddr_i == 9 || bus.waddr_i == 11) ? 32'($urandom_range(0, 12)) : $urandom;
        bus.raddr_i = ($urandom_range(0, 2) == 0) ? bus.waddr_i : addrs[$urandom_range(0, 7)];
      end
      #1;
      model_check(cyc);
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
CP0 register file plus exception-commit sequencer for the 5-stage MIPS-32 core. Consumes the prioritised 32-bit excepttype code and the MEM-stage PC. Updates Status/Cause/EPC/BadVAddr, drives pipeline flush and redirect PC, and runs the Count/Compare timer. Sits beside MEM/WB; services MTC0/MFC0 and ERET.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for every exception except ERET
COUNT_DIV, 1, Count increments once every COUNT_DIV+1 cycles (1 gives half-rate)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  MEM stage held; no commit while high
excepttype_i  in  32  prioritised code, 0 means none (1,4,5,8,9,a,c,e)
pc_i  in  32  PC of MEM-stage instruction
in_delayslot_i  in  1  MEM instruction is in a branch delay slot
bad_addr_i  in  32  faulting address for codes 4/5
int_i  in  6  hardware interrupt lines, level-sensitive
we_i  in  1  MTC0 write enable
waddr_i  in  5  MTC0 register number
wdata_i  in  32  MTC0 data
raddr_i  in  5  MFC0 register number
rdata_o  out  32  MFC0 data, combinational
flush_o  out  1  flush IF..MEM, combinational
newpc_o  out  32  redirect PC, valid when flush_o
status_o, cause_o, epc_o  out  32 each  live register values
timer_int_o  out  1  timer interrupt pending

Behaviour:
- Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
- Unimplemented register numbers read 0; writes to them are ignored.
- Reset values:
  - Status = 32'h00400000 (BEV=1); all other registers 0.
  - timer_int_o=0, flush_o=0, newpc_o=0, FSM=IDLE.
  - Reset is async: it aborts any state immediately.
- Writable fields:
  - Status: [15:8] IM, [1] EXL, [0] IE.
  - Cause: [9:8] only.
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr: read-only.
- Cause[14:10] <= int_i[4:0] every cycle.
- Cause[15] <= int_i[5] | timer_int_o every cycle.
- Timer:
  - Divider counter wraps at COUNT_DIV; Count += 1 on wrap, mod 2^32.
  - When Count==Compare and Compare!=0, timer_int_o is set on the next edge.
  - MTC0 to Compare clears timer_int_o.
  - MTC0 to Count overrides that cycle's increment and clears the divider.
- FSM states: IDLE, FLUSH.
- IDLE commit condition: excepttype_i!=0 and stall=0. On commit:
  - flush_o=1 combinationally.
  - ERET (e): newpc_o=EPC; Status.EXL<=0.
  - Other codes: newpc_o=EXC_VECTOR.
  - Other codes with Status.EXL=0:
    - EPC <= in_delayslot_i ? pc_i-4 : pc_i.
    - Cause.BD[31] <= in_delayslot_i.
  - Other codes with Status.EXL=1: EPC and BD unchanged.
  - Other codes: Status.EXL<=1.
  - Cause.ExcCode[6:2] mapping:
    - 1 -> 0x00, 4 -> 0x04, 5 -> 0x05, 8 -> 0x08
    - 9 -> 0x09, a -> 0x0A, c -> 0x0C
    - any other nonzero code -> 0x0A
  - Codes 4/5: BadVAddr <= bad_addr_i.
  - Next state: FLUSH.
- FLUSH state:
  - Lasts exactly 1 cycle; flush_o=0; excepttype_i is ignored (bubble).
  - Returns to IDLE.
- MTC0 interaction:
  - An MTC0 in a commit cycle is dropped entirely; the exception wins.
  - MTC0 otherwise takes effect at the next edge.
- Read path:
  - rdata_o forwards wdata_i, masked to writable fields, when we_i && waddr_i==raddr_i && no commit.
  - Otherwise rdata_o reads the register.
- stall=1 with nonzero excepttype_i: no flush and no state change; the exception commits on the first unstalled cycle.

Test Plan:
- Reset then read 12/13/14 -> 32'h00400000/0/0; flush_o=0; timer_int_o=0.
- excepttype=8, pc=32'h80001000, delayslot=0 -> same-cycle flush_o=1, newpc=BFC00380; next cycle EPC=80001000, ExcCode=8, EXL=1, flush_o=0.
- excepttype=4, pc=32'h80002004, delayslot=1, bad=32'h00000003 -> EPC=80002000, BD=1, BadVAddr=3; a second excepttype=c in the following cycle is ignored.
- With EXL=1, raise excepttype=c -> EPC unchanged, ExcCode=0x0C. Then excepttype=e -> newpc=old EPC, EXL=0.
- MTC0 Compare=6, Count=0, COUNT_DIV=1 -> timer_int_o=1 about 13 cycles later; Cause[15]=1 one cycle after that; MTC0 Compare clears it.
- Same cycle: we_i to EPC with wdata=32'h1234 and excepttype=8 -> EPC=pc_i, not 32'h1234. Separately, assert rst during the FLUSH cycle -> immediate return to reset values.
